dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Sits directly downstream of the pipeline MEM stage, between the datapath data port and a
//  multi-cycle data bus with a req/ack handshake.
//  Latches each MEM-stage read or write, runs the bus transaction and holds `stall` high until
//  it completes, so the hazard logic freezes pc_en and all pipeline-register enables.
//  Returns registered read data and flags bus timeouts with a sticky error.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width (one word per transaction)
//  TIMEOUT  255  max REQ-state cycles without bus_ack before abort; legal range 1..65535
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  mem_read   in   1   MEM-stage read request (level)
//  mem_write  in   1   MEM-stage write request (level)
//  adr        in   AW  byte address from the MEM stage
//  wdata      in   DW  write data from the MEM stage
//  rdata      out  DW  read data to the MEM stage (data_in)
//  stall      out  1   1 = MEM access in progress; freeze the whole pipeline
//  err        out  1   sticky bus-timeout flag
//  bus_req    out  1   bus request, held until ack or timeout
//  bus_we     out  1   1 = write, 0 = read
//  bus_adr    out  AW  word-aligned address: {adr_q[AW-1:2],2'b00}
//  bus_wdata  out  DW  registered write data
//  bus_ack    in   1   single-cycle completion strobe from the bus
//  bus_rdata  in   DW  read data; valid only in the bus_ack cycle
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; every output 0, including rdata, stall, err, bus_req, bus_we, bus_adr, bus_wdata.
//   - Internal adr_q/wdata_q/cnt are 0.
//  FSM states: IDLE, REQ, DONE.
//  IDLE:
//   - stall = mem_read|mem_write (combinational, same cycle as the request).
//   - On a request: latch adr_q, wdata_q and we_q = mem_write (write wins if both are 1);
//     clear cnt; go to REQ.
//   - With no request: stay in IDLE, stall=0.
//  REQ:
//   - Outputs: bus_req=1, stall=1; bus_we/bus_adr/bus_wdata driven from the latched values,
//     stable for the whole state.
//   - bus_ack=1, read: rdata <= bus_rdata; go to DONE.
//   - bus_ack=1, write: rdata unchanged; go to DONE.
//   - bus_ack=0: cnt++ (16-bit, saturating).
//   - cnt==TIMEOUT-1 with no ack: err <= 1; if the request is a read, rdata <= 0; go to DONE.
//   - bus_req drops in the cycle after ack or timeout.
//  DONE (exactly 1 cycle):
//   - stall=0, so the pipeline advances at this edge; rdata is valid and stable.
//   - mem_read/mem_write are ignored (the same instruction is still in MEM).
//   - Go to IDLE.
//  Latency and throughput:
//   - Minimum request-to-DONE latency is 2 cycles (ack in the first REQ cycle).
//   - Back-to-back accesses are legal: a new request is sampled in the IDLE cycle right after DONE.
//  Holding values:
//   - rdata holds its last value until the next read completes.
//   - err clears only on reset.
//  Bus misbehaviour:
//   - A bus_ack outside REQ is ignored.
//   - bus_rdata is sampled only in the REQ ack cycle.
//  Reset mid-transaction: bus_req and stall drop asynchronously, the transaction is abandoned
//  and no write-back occurs.
//  Address alignment: adr[1:0] is dropped on the bus; sub-word placement is the MEM stage's job.
// TESTING
//  1. Reset: rst=0 with random inputs -> all outputs 0; release -> IDLE, stall=0.
//  2. Read, ack on 3rd REQ cycle, bus_rdata=32'h1234_5678, adr=32'h0000_0103:
//     bus_adr=32'h0000_0100, stall high 4 cycles, rdata=32'h1234_5678 in DONE.
//  3. Write adr=32'h40, wdata=32'hCAFE_F00D, immediate ack:
//     bus_we=1 with stable data, stall high 2 cycles, rdata unchanged.
//  4. Read then write back-to-back -> second bus_req asserts in the 2nd cycle after DONE;
//     both complete in order.
//  5. TIMEOUT=4, read, no ack -> bus_req drops after 4 REQ cycles; err=1; rdata=0;
//     stall falls; err persists through later good accesses.
//  6. rst asserted in REQ -> bus_req=0 and stall=0 immediately; a subsequent read works normally.

Source files
------------

// File: rtl/dmem_bus_if.sv
// Data-bus side of the MEM-stage bridge: req/ack handshake,
// word address, write data and read data returned with ack.
interface dmem_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_adr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_adr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_adr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage to multi-cycle data bus bridge: latches one access,
// runs req/ack, stalls the pipeline, returns registered rdata.
// Ports: clk, rst (async, active-low), mem_read/mem_write/adr/wdata
// from MEM, rdata/stall/err back to MEM, bus = master side of bus.
module dmem_bridge #(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          err,
  dmem_bus_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-3:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_we;
  logic          r_err;
  logic [15:0]   r_cnt;
  logic          w_req;
  logic          w_ack;
  logic          w_tmo;
  logic          w_unused_adr;

  // Byte lanes are placed by the MEM stage; the bus is word-only.
  assign w_unused_adr = ^adr[1:0];

  assign w_req = mem_read | mem_write;
  assign w_ack = (r_state == S_REQ) & bus.bus_ack;
  assign w_tmo = (r_state == S_REQ) & ~bus.bus_ack
               & (r_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_next = S_REQ;
      S_REQ:   if (w_ack || w_tmo) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // rst gates the IDLE stall so it reads 0 while held in reset.
  always_comb begin
    stall       = 1'b0;
    bus.bus_req = 1'b0;
    unique case (r_state)
      S_IDLE: stall = rst & w_req;
      S_REQ: begin
        stall       = 1'b1;
        bus.bus_req = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr   <= adr[AW-1:2];
            r_wdata <= wdata;
            r_we    <= mem_write;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            if (!r_we) r_rdata <= bus.bus_rdata;
          end else if (w_tmo) begin
            r_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_we    = r_we;
  assign bus.bus_adr   = {r_adr, 2'b00};
  assign bus.bus_wdata = r_wdata;
  assign rdata         = r_rdata;
  assign err           = r_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: vector table of MEM accesses, a bus
// responder with a scoreboard of expected bus transactions.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  dmem_bus_if #(.AW(32), .DW(32)) bif ();

  dmem_bridge #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .adr       (adr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .bus       (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
  } bus_exp_t;

  typedef struct {
    bit          we;
    bit          both;
    logic [31:0] a;
    logic [31:0] d;
    int          ackat;
    logic [31:0] brd;
    int          st;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  bus_exp_t    sb[$];
  bus_exp_t    cur;
  int          ack_at = 0;
  logic [31:0] ack_data = '0;
  bit          stray_ack = 1'b0;
  int          req_n = 0;
  int          last_req = 0;
  int          first_req_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Bus slave: acks on REQ cycle ack_at (0 = never) and checks
  // each REQ cycle against the expected transaction.
  initial begin
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    cur = '{we: 1'b0, adr: '0, wd: '0};
    forever begin
      @(negedge clk);
      if (!rst || !bif.bus_req) begin
        if (req_n > 0) last_req = req_n;
        req_n         = 0;
        bif.bus_ack   = stray_ack & rst;
        bif.bus_rdata = $urandom;
      end else begin
        req_n++;
        if (req_n == 1) begin
          first_req_cyc = cyc;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got bus_req want none");
          end else begin
            cur = sb.pop_front();
          end
        end
        chk("bus_we", {31'b0, bif.bus_we}, {31'b0, cur.we});
        chk("bus_adr", bif.bus_adr, cur.adr);
        chk("bus_wdata", bif.bus_wdata, cur.wd);
        if (ack_at != 0 && req_n == ack_at) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = ack_data;
        end else begin
          bif.bus_ack   = 1'b0;
          bif.bus_rdata = $urandom;
        end
      end
    end
  end

  // Starts in IDLE just after a rising edge; returns the same way.
  task automatic access(input vec_t v, input string nm,
                        output int done_c);
    bus_exp_t e;
    int n;
    ack_at   = v.ackat;
    ack_data = v.brd;
    e.we  = v.we;
    e.adr = {v.a[31:2], 2'b00};
    e.wd  = v.d;
    sb.push_back(e);
    adr       = v.a;
    wdata     = v.d;
    mem_write = v.we;
    mem_read  = !v.we || v.both;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    done_c = cyc;
    chk({nm, "_stall"}, 32'(n), 32'(v.st));
    chk({nm, "_rdata"}, rdata, v.rd);
    chk({nm, "_err"}, {31'b0, err}, {31'b0, v.er});
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[5];
  vec_t v;
  int   dc;
  int   dc1;

  initial begin
    vt[0] = '{we: 0, both: 0, a: 32'h0000_0103, d: 32'h0,
              ackat: 3, brd: 32'h1234_5678, st: 4,
              rd: 32'h1234_5678, er: 0};
    vt[1] = '{we: 1, both: 0, a: 32'h0000_0040, d: 32'hCAFE_F00D,
              ackat: 1, brd: 32'h9999_9999, st: 2,
              rd: 32'h1234_5678, er: 0};
    vt[2] = '{we: 0, both: 0, a: 32'h0000_0008, d: 32'h1,
              ackat: 1, brd: 32'hA5A5_0001, st: 2,
              rd: 32'hA5A5_0001, er: 0};
    vt[3] = '{we: 1, both: 1, a: 32'hFFFF_FFFE, d: 32'h0BAD_BEEF,
              ackat: 2, brd: 32'h5A5A_5A5A, st: 3,
              rd: 32'hA5A5_0001, er: 0};
    vt[4] = '{we: 0, both: 0, a: 32'h0000_0200, d: 32'h2,
              ackat: 4, brd: 32'hDEAD_0004, st: 5,
              rd: 32'hDEAD_0004, er: 0};

    for (int i = 0; i < 4; i++) begin
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      adr       = $urandom;
      wdata     = $urandom;
      stray_ack = 1'($urandom);
      @(negedge clk);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_req", {31'b0, bif.bus_req}, 32'h0);
      chk("rst_we", {31'b0, bif.bus_we}, 32'h0);
      chk("rst_adr", bif.bus_adr, 32'h0);
      chk("rst_wdata", bif.bus_wdata, 32'h0);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stray_ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'b0, stall}, 32'h0);
    chk("idle_req", {31'b0, bif.bus_req}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      access(vt[i], $sformatf("vec%0d", i), dc);
    end

    v = '{we: 0, both: 0, a: 32'h10, d: 32'h0, ackat: 2,
          brd: 32'h1111_2222, st: 3, rd: 32'h1111_2222, er: 0};
    access(v, "b2b_rd", dc1);
    v = '{we: 1, both: 0, a: 32'h14, d: 32'h3333_4444, ackat: 1,
          brd: 32'h0, st: 2, rd: 32'h1111_2222, er: 0};
    access(v, "b2b_wr", dc);
    chk("b2b_gap", 32'(first_req_cyc - dc1), 32'd2);

    v = '{we: 0, both: 0, a: 32'h20, d: 32'h0, ackat: 0,
          brd: 32'h0, st: 5, rd: 32'h0, er: 1};
    access(v, "tmo", dc);
    chk("tmo_req_cycles", 32'(last_req), 32'd4);
    v = '{we: 1, both: 0, a: 32'h24, d: 32'h5555, ackat: 1,
          brd: 32'h0, st: 2, rd: 32'h0, er: 1};
    access(v, "tmo_wr", dc);
    v = '{we: 0, both: 0, a: 32'h28, d: 32'h0, ackat: 2,
          brd: 32'h6666_7777, st: 3, rd: 32'h6666_7777, er: 1};
    access(v, "tmo_rd", dc);

    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_stall", {31'b0, stall}, 32'h0);
      chk("stray_req", {31'b0, bif.bus_req}, 32'h0);
      chk("stray_rdata", rdata, 32'h6666_7777);
    end
    stray_ack = 1'b0;
    @(posedge clk);
    #1;

    ack_at = 0;
    sb.push_back('{we: 1'b0, adr: 32'h30, wd: 32'h0});
    adr      = 32'h30;
    wdata    = 32'h0;
    mem_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_req_pre", {31'b0, bif.bus_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_req", {31'b0, bif.bus_req}, 32'h0);
    chk("mid_stall", {31'b0, stall}, 32'h0);
    chk("mid_err", {31'b0, err}, 32'h0);
    chk("mid_rdata", rdata, 32'h0);
    mem_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    v = '{we: 0, both: 0, a: 32'h34, d: 32'h0, ackat: 1,
          brd: 32'h7777_8888, st: 2, rd: 32'h7777_8888, er: 0};
    access(v, "post_rst", dc);

    chk("sb_left", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
